muldiv_unit: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit for the MIPS core.
- Sits beside the combinational `alu`.
- Executes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers, and services MTHI/MTLO writes.
- Adds what the ALU lacks: WIDTH generalisation, a start/busy/done handshake, and pipeline flush.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes and FSM state encoding for the MIPS multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'b001;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'b010;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_MTHI  = 3'b100;
  localparam logic [2:0] MULDIV_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'd0,
    MULDIV_ST_RUN  = 2'd1,
    MULDIV_ST_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// 2*WIDTH accumulator ({upper, lower} = {partial product, multiplier} or {remainder, quotient}).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    // Only taken when ge holds, so the difference always fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (mode_div) begin
      acc_nxt = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                   : {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO, start/busy/done and flush.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_dw(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  muldiv_state_e      state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step, result;
  logic [WIDTH-1:0]   opnd, a_mag, b_mag, hi_q, lo_q;
  logic               mode_div, neg_full, neg_hi, neg_lo;
  logic               busy_q, done_q;
  logic               is_mul, is_div, is_signed, sa, sb, b_zero, accept;

  assign is_mul    = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
  assign is_div    = (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_DIVU);
  assign is_signed = (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
  assign sa        = is_signed & a[WIDTH-1];
  assign sb        = is_signed & b[WIDTH-1];
  assign a_mag     = cond_neg(a, sa);
  assign b_mag     = cond_neg(b, sb);
  assign b_zero    = (b == '0);
  assign accept    = start && !flush && (state == MULDIV_ST_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (mode_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_nxt  (acc_step)
  );

  // Products negate as one 2*WIDTH value; quotient and remainder carry separate signs.
  assign result = neg_full ? cond_neg_dw(acc, 1'b1)
                           : {cond_neg(acc[2*WIDTH-1:WIDTH], neg_hi),
                              cond_neg(acc[WIDTH-1:0], neg_lo)};

  always_comb begin
    state_nxt = state;
    case (state)
      MULDIV_ST_IDLE: begin
        if (accept && is_div) begin
          state_nxt = b_zero ? MULDIV_ST_FIX : MULDIV_ST_RUN;
        end else if (accept && is_mul) begin
`ifdef MULDIV_FAST_MULT_EN
          state_nxt = MULDIV_ST_FIX;
`else
          state_nxt = MULDIV_ST_RUN;
`endif
        end
      end
      MULDIV_ST_RUN: begin
        if (cnt == CNT_W'(1)) state_nxt = MULDIV_ST_FIX;
      end
      MULDIV_ST_FIX: state_nxt = MULDIV_ST_IDLE;
      default:       state_nxt = MULDIV_ST_IDLE;
    endcase
    if (flush) state_nxt = MULDIV_ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MULDIV_ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      mode_div <= 1'b0;
      neg_full <= 1'b0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != MULDIV_ST_IDLE);
      done_q <= (state == MULDIV_ST_FIX) && !flush;

      if (accept) begin
        cnt <= CNT_W'(WIDTH);
        if (is_mul) begin
          mode_div <= 1'b0;
          neg_full <= sa ^ sb;
          neg_hi   <= 1'b0;
          neg_lo   <= 1'b0;
          opnd     <= a_mag;
`ifdef MULDIV_FAST_MULT_EN
          acc      <= {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
          acc      <= {{WIDTH{1'b0}}, b_mag};
`endif
        end else if (is_div) begin
          mode_div <= 1'b1;
          neg_full <= 1'b0;
          opnd     <= b_mag;
          // Divide by zero bypasses the iterations and sign fixup entirely.
          if (b_zero) begin
            acc    <= {a, {WIDTH{1'b1}}};
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
          end else begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            neg_hi <= sa;
            neg_lo <= sa ^ sb;
          end
        end else if (op == MULDIV_OP_MTHI) begin
          hi_q <= a;
        end else if (op == MULDIV_OP_MTLO) begin
          lo_q <= a;
        end
      end

      if (state == MULDIV_ST_RUN) begin
        acc <= acc_step;
        cnt <= cnt - CNT_W'(1);
      end

      if ((state == MULDIV_ST_FIX) && !flush) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random mul/div against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b111;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from plain integer arithmetic on the architectural definitions.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      MULDIV_OP_MULT:  begin q = sx * sy; return q; end
      MULDIV_OP_MULTU: begin p = ux * uy; return p; end
      MULDIV_OP_DIV: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MULDIV_OP_DIVU: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        p = ux / uy;
        q = longint'(ux % uy);
        return {q[31:0], p[31:0]};
      end
      default: return 64'b0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int          n, lat;
    exp = model(o, x, y);
    if (o == MULDIV_OP_DIV || o == MULDIV_OP_DIVU) lat = (y == 32'b0) ? 1 : W + 1;
    else lat = MUL_LAT;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_accept"}, 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " hi_lo"}, {hi, lo}, exp);
    check({tag, " busy_at_done"}, 64'(busy), 64'(0));
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] x);
    op = o; a = x; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [63:0] saved;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
    run_op("mult_neg", MULDIV_OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_neg hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    @(posedge clk); #1;
    check("mult_neg done_one_cycle", 64'(done), 64'(0));
    run_op("multu_max", MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_neg7", MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    check("div_neg7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7", MULDIV_OP_DIVU, 32'h7, 32'h2);
    check("divu_7 const", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op("div_ovf", MULDIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("div_zero", MULDIV_OP_DIV, 32'h1234_5678, 32'h0);
    check("div_zero const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    run_op("divu_zero", MULDIV_OP_DIVU, 32'h8765_4321, 32'h0);

    // Random mul/div against the model, issued back to back
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: ry = 32'hFFFF_FFFF;
        2: rx = 32'h8000_0000;
        3: ry = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", ro, rx, ry);
    end

    // Flush mid-divide with an ignored start while busy
    saved = {hi, lo};
    op = MULDIV_OP_DIVU; a = 32'h0F0F_0F0F; b = 32'h0000_0013; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    op = MULDIV_OP_MTHI; a = 32'hAAAA_5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("flush busy_before", 64'(busy), 64'(1));
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_after", 64'(busy), 64'(0));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("flush no_done", 64'(seen), 64'(0));
    check("flush hi_lo_kept", {hi, lo}, saved);

    // Flush together with start in IDLE drops the request
    op = MULDIV_OP_MTHI; a = 32'h1111_2222; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start mt_suppressed", {hi, lo}, saved);
    op = MULDIV_OP_MULT; a = 32'h5; b = 32'h7; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start no_busy", 64'(busy), 64'(0));

    // No-op code is ignored
    op = 3'b110; a = 32'h9999_9999; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("noop busy", 64'(busy), 64'(0));
    check("noop hi_lo", {hi, lo}, saved);

    // MTHI / MTLO
    mt_op("mthi", MULDIV_OP_MTHI, 32'hDEAD_BEEF);
    check("mthi hi", 64'(hi), 64'h0000_0000_DEAD_BEEF);
    mt_op("mtlo", MULDIV_OP_MTLO, 32'h0000_CAFE);
    check("mtlo hi_lo", {hi, lo}, 64'hDEAD_BEEF_0000_CAFE);

    // Asynchronous reset in the middle of a multiply
    op = MULDIV_OP_MULT; a = 32'h0000_1234; b = 32'h0000_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_mid busy_before", 64'(busy), 64'(MUL_LAT > 1 ? 1 : 0));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", 64'(busy), 64'(0));
    check("rst_mid done", 64'(done), 64'(0));
    check("rst_mid hi", 64'(hi), 64'(0));
    check("rst_mid lo", 64'(lo), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    check("rst_mid stays_clear", {hi, lo}, 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
